conv_neuron_array: RTL

CONV_NEURON_ARRAY -- requirements
Module: conv_neuron_array

---
 rtl/cnn_pkg.sv | 30 +++
 rtl/conv_mac_lane.sv | 56 +++++
 rtl/conv_neuron_array.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared state encodings and the result quantiser for conv_neuron_array.
package cnn_pkg;

  typedef enum logic [1:0] {W_IDLE, W_BIAS, W_TAPS} w_state_t;
  typedef enum logic {D_IDLE, D_DRAIN} d_state_t;

  // Shift, then clamp to [0 or -2^(w-1), 2^(w-1)-1]; RELU clamps negatives to zero.
  function automatic logic signed [31:0] quantise(input logic signed [63:0] acc,
                                                  input int shift, input int width,
                                                  input bit relu);
    logic signed [63:0] s, hi, lo;
    s  = acc >>> shift;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = relu ? 64'sd0 : -(64'sd1 <<< (width - 1));
    if (s > hi) return 32'(hi);
    if (s < lo) return 32'(lo);
    return 32'(s);
  endfunction

  // The RELU zero-clamp is the activation itself, not an overflow.
  function automatic bit is_sat(input logic signed [63:0] acc, input int shift,
                                input int width, input bit relu);
    logic signed [63:0] s, hi, lo;
    s  = acc >>> shift;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    return (s > hi) || (!relu && (s < lo));
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One neuron: bias register, tap RAM, registered read, multiply and accumulate stages.
module conv_mac_lane #(
  parameter int FEATURE_WIDTH    = 8,
  parameter int WEIGHT_WIDTH     = 8,
  parameter int WEIGHT_MEM_ORDER = 5,
  parameter int BIAS_SHIFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bias_we,
  input  logic                       tap_we,
  input  logic [WEIGHT_MEM_ORDER-1:0] tap_addr,
  input  logic [WEIGHT_WIDTH-1:0]    wdata,
  input  logic                       rd_en,
  input  logic [WEIGHT_MEM_ORDER-1:0] rd_addr,
  input  logic                       rd_in_range,
  input  logic                       mul_en,
  input  logic [FEATURE_WIDTH-1:0]   feature,
  input  logic                       acc_en,
  input  logic                       acc_first,
  output logic signed [FEATURE_WIDTH+WEIGHT_WIDTH+WEIGHT_MEM_ORDER:0] acc
);

  localparam int PW = FEATURE_WIDTH + WEIGHT_WIDTH + 1;
  localparam int AW = FEATURE_WIDTH + WEIGHT_WIDTH + WEIGHT_MEM_ORDER + 1;

  logic [WEIGHT_WIDTH-1:0] mem [1 << WEIGHT_MEM_ORDER];
  logic [WEIGHT_WIDTH-1:0] bias;
  logic [WEIGHT_WIDTH-1:0] weight_q;
  logic signed [PW-1:0]    w_ext, f_ext, prod_q;
  logic signed [AW-1:0]    bias_term, prod_ext;

  // Weights survive reset; only the datapath registers are cleared.
  always_ff @(posedge clk) begin
    if (tap_we)  mem[tap_addr] <= wdata;
    if (bias_we) bias <= wdata;
  end

  assign w_ext     = {{(PW-WEIGHT_WIDTH){weight_q[WEIGHT_WIDTH-1]}}, weight_q};
  assign f_ext     = {{(PW-FEATURE_WIDTH){1'b0}}, feature};
  assign prod_ext  = {{(AW-PW){prod_q[PW-1]}}, prod_q};
  assign bias_term = {{(AW-WEIGHT_WIDTH){bias[WEIGHT_WIDTH-1]}}, bias} <<< BIAS_SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q <= '0;
      prod_q   <= '0;
      acc      <= '0;
    end else begin
      if (rd_en)  weight_q <= rd_in_range ? mem[rd_addr] : '0;
      if (mul_en) prod_q   <= w_ext * f_ext;
      if (acc_en) acc      <= acc_first ? bias_term + prod_ext : acc + prod_ext;
    end
  end

endmodule

// File: rtl/conv_neuron_array.sv
// NUM_NEURONS parallel MAC lanes on one feature stream, with weight loader and result drain.
// Define CONV_NEURON_ARRAY_OVF_CNT_EN to add the ovf_count saturation counter port.
module conv_neuron_array
  import cnn_pkg::*;
#(
  parameter int FEATURE_WIDTH    = 8,
  parameter int WEIGHT_WIDTH     = 8,
  parameter int WEIGHT_MEM_ORDER = 5,
  parameter int NUM_NEURONS      = 4,
  parameter int OUTPUT_WIDTH     = 8,
  parameter int OUTPUT_SHIFT     = 0,
  parameter int BIAS_SHIFT       = 0,
  parameter int RELU             = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [FEATURE_WIDTH-1:0]       feature_stream,
  input  logic                           feature_valid,
  input  logic                           feature_first,
  input  logic                           feature_last,
  output logic                           feature_ready,
  input  logic [WEIGHT_WIDTH-1:0]        weight_stream,
  input  logic                           weight_valid,
  input  logic                           weight_first,
  input  logic                           weight_last,
  output logic [OUTPUT_WIDTH-1:0]        output_stream,
  output logic [$clog2(NUM_NEURONS)-1:0] output_index,
  output logic                           output_valid,
  input  logic                           output_ready
`ifdef CONV_NEURON_ARRAY_OVF_CNT_EN
  , output logic [15:0]                  ovf_count
`endif
);

  localparam int WMO = WEIGHT_MEM_ORDER;
  localparam int IW  = $clog2(NUM_NEURONS);
  localparam int AW  = FEATURE_WIDTH + WEIGHT_WIDTH + WEIGHT_MEM_ORDER + 1;
  localparam logic [WMO:0]  DEPTH    = {1'b1, {WMO{1'b0}}};
  localparam logic [IW-1:0] LAST_SEL = IW'(NUM_NEURONS - 1);

  w_state_t w_state, w_next;
  logic [IW-1:0] w_sel, w_sel_next, wr_sel;
  logic [WMO:0]  w_addr, w_addr_next, tap_len, tap_len_next;
  logic          loaded, loaded_next, bias_wr, tap_wr, abort;

  always_comb begin
    w_next       = w_state;
    w_sel_next   = w_sel;
    w_addr_next  = w_addr;
    tap_len_next = tap_len;
    loaded_next  = loaded;
    wr_sel       = w_sel;
    bias_wr      = 1'b0;
    tap_wr       = 1'b0;
    abort        = 1'b0;
    if (weight_valid && weight_first) begin
      wr_sel       = '0;
      bias_wr      = 1'b1;
      abort        = 1'b1;
      w_sel_next   = '0;
      w_addr_next  = '0;
      tap_len_next = '0;
      loaded_next  = 1'b0;
      w_next       = W_TAPS;
    end else if (weight_valid) begin
      case (w_state)
        W_BIAS: begin
          bias_wr     = 1'b1;
          w_addr_next = '0;
          w_next      = W_TAPS;
        end
        W_TAPS: begin
          // Neuron 0 defines the tap count; later segments cannot exceed it.
          tap_wr = (w_addr < DEPTH) && ((w_sel == '0) || (w_addr < tap_len));
          if (w_addr < DEPTH) w_addr_next = w_addr + 1'b1;
          if ((w_sel == '0) && (w_addr < DEPTH)) tap_len_next = w_addr + 1'b1;
          if (weight_last) begin
            if (w_sel == LAST_SEL) begin
              w_next      = W_IDLE;
              loaded_next = 1'b1;
            end else begin
              w_sel_next = w_sel + 1'b1;
              w_next     = W_BIAS;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_sel   <= '0;
      w_addr  <= '0;
      tap_len <= '0;
      loaded  <= 1'b0;
    end else begin
      w_state <= w_next;
      w_sel   <= w_sel_next;
      w_addr  <= w_addr_next;
      tap_len <= tap_len_next;
      loaded  <= loaded_next;
    end
  end

  d_state_t d_state, d_next;
  logic [IW-1:0] out_idx, idx_next;
  logic          busy, accept, capture, drain_done;
  logic [WMO:0]  rd_addr, use_addr, a1;
  logic [FEATURE_WIDTH-1:0] f1, f2;
  logic v1, v2, v3, v4, first1, first2, first3, last1, last2, last3, last4;

  assign feature_ready = (w_state == W_IDLE) && loaded && !busy;
  assign accept        = feature_valid && feature_ready;
  assign use_addr      = feature_first ? '0 : rd_addr;
  assign capture       = v4 && last4 && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      busy    <= 1'b0;
      {v1, v2, v3, v4} <= '0;
      {first1, first2, first3} <= '0;
      {last1, last2, last3, last4} <= '0;
      a1 <= '0;
      f1 <= '0;
      f2 <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
      first2 <= first1;
      first3 <= first2;
      last2  <= last1;
      last3  <= last2;
      last4  <= last3;
      f2     <= f1;
      if (accept) begin
        a1      <= use_addr;
        f1      <= feature_stream;
        first1  <= feature_first;
        last1   <= feature_last;
        rd_addr <= (use_addr == DEPTH) ? use_addr : use_addr + 1'b1;
        if (feature_last) busy <= 1'b1;
      end
      if (drain_done) busy <= 1'b0;
      // A weight reload kills everything in flight, including a just-accepted beat.
      if (abort) begin
        {v1, v2, v3, v4} <= '0;
        if (d_state == D_IDLE) busy <= 1'b0;
      end
    end
  end

  logic signed [AW-1:0] lane_acc [NUM_NEURONS];

  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_lane
    conv_mac_lane #(
      .FEATURE_WIDTH   (FEATURE_WIDTH),
      .WEIGHT_WIDTH    (WEIGHT_WIDTH),
      .WEIGHT_MEM_ORDER(WEIGHT_MEM_ORDER),
      .BIAS_SHIFT      (BIAS_SHIFT)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .bias_we    (bias_wr && (wr_sel == IW'(i))),
      .tap_we     (tap_wr && (wr_sel == IW'(i))),
      .tap_addr   (w_addr[WMO-1:0]),
      .wdata      (weight_stream),
      .rd_en      (v1),
      .rd_addr    (a1[WMO-1:0]),
      .rd_in_range(a1 < tap_len),
      .mul_en     (v2),
      .feature    (f2),
      .acc_en     (v3),
      .acc_first  (first3),
      .acc        (lane_acc[i])
    );
  end

  logic [OUTPUT_WIDTH-1:0] bank [NUM_NEURONS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) bank[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_NEURONS; i++)
        bank[i] <= OUTPUT_WIDTH'(quantise(64'(lane_acc[i]), OUTPUT_SHIFT, OUTPUT_WIDTH, RELU != 0));
    end
  end

  always_comb begin
    d_next     = d_state;
    idx_next   = out_idx;
    drain_done = 1'b0;
    case (d_state)
      D_IDLE: begin
        if (capture) begin
          d_next   = D_DRAIN;
          idx_next = '0;
        end
      end
      D_DRAIN: begin
        if (output_ready) begin
          if (out_idx == LAST_SEL) begin
            d_next     = D_IDLE;
            idx_next   = '0;
            drain_done = 1'b1;
          end else begin
            idx_next = out_idx + 1'b1;
          end
        end
      end
      default: d_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_state <= D_IDLE;
      out_idx <= '0;
    end else begin
      d_state <= d_next;
      out_idx <= idx_next;
    end
  end

  assign output_valid  = (d_state == D_DRAIN);
  assign output_index  = out_idx;
  assign output_stream = output_valid ? bank[out_idx] : '0;

`ifdef CONV_NEURON_ARRAY_OVF_CNT_EN
  logic [16:0] ovf_sum;

  always_comb begin
    ovf_sum = {1'b0, ovf_count};
    for (int i = 0; i < NUM_NEURONS; i++)
      if (is_sat(64'(lane_acc[i]), OUTPUT_SHIFT, OUTPUT_WIDTH, RELU != 0))
        ovf_sum = ovf_sum + 17'd1;
    if (ovf_sum > 17'h0FFFF) ovf_sum = 17'h0FFFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf_count <= '0;
    else if (capture) ovf_count <= 16'(ovf_sum);
  end
`endif

endmodule
